mm_seq_ctrl: RTL and testbench

Wishbone-mapped controller that sequences an external single multiply-accumulate (MAC) datapath to compute C = A x B for NxN unsigned matrices. Holds the operand and result register files, steps the MAC through every row/column/inner-index combination, and captures each accumulated result. Sits in the user project between the management-SoC Wishbone slave port and the MAC unit, and drives a user interrupt line on completion.

---
 rtl/mm_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mm_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mm_seq_ctrl.sv
// Wishbone-mapped sequencer that drives an external MAC unit to compute C = A x B
// for NxN unsigned matrices, holding the A/B/C register files and a completion interrupt.
module mm_seq_ctrl #(
  parameter int unsigned N        = 2,
  parameter int unsigned W        = 8,
  parameter int unsigned ACC_W    = 2*W + $clog2(N),
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             mac_clr_o,
  output logic             mac_en_o,
  output logic [W-1:0]     mac_a_o,
  output logic [W-1:0]     mac_b_o,
  input  logic [ACC_W-1:0] mac_acc_i,
  output logic             busy_o,
  output logic             irq_o
);

  localparam int unsigned NN = N*N;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned EW = $clog2(NN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
  logic             done_q, done_d;
  logic             irq_en_q, irq_en_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [W-1:0]     a_q [NN];
  logic [W-1:0]     a_d [NN];
  logic [W-1:0]     b_q [NN];
  logic [W-1:0]     b_d [NN];
  logic [ACC_W-1:0] c_q [NN];
  logic [ACC_W-1:0] c_d [NN];

  logic             hit, req, busy, e_ok, ctrl_sel;
  logic [7:0]       off;
  logic [3:0]       e;
  logic [EW-1:0]    elem, a_idx, b_idx, c_idx;
  logic             unused_ok;

  assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};

  assign off      = wbs_adr_i[7:0];
  assign e        = off[5:2];
  assign e_ok     = ({28'b0, e} < NN);
  assign elem     = e[EW-1:0];
  assign ctrl_sel = (off[7:6] == 2'b00) && (off[5:0] == 6'd0);
  assign hit      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  // Holding off while ack is high keeps ack a single-cycle pulse even if stb stays up.
  assign req      = hit & ~ack_q;
  assign busy     = (state_q != S_IDLE);

  assign a_idx = EW'(i_q * N + k_q);
  assign b_idx = EW'(k_q * N + j_q);
  assign c_idx = EW'(i_q * N + j_q);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    ack_d    = req;
    dat_d    = '0;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;

    case (state_q)
      S_CLR: begin
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        k_d = k_q + IW'(1);
        if (k_q == IW'(N-1)) state_d = S_WAIT;
      end
      S_WAIT: state_d = S_STORE;
      S_STORE: begin
        c_d[c_idx] = mac_acc_i;
        if (j_q < IW'(N-1)) begin
          j_d     = j_q + IW'(1);
          state_d = S_CLR;
        end else if (i_q < IW'(N-1)) begin
          j_d     = '0;
          i_d     = i_q + IW'(1);
          state_d = S_CLR;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // Bus side is evaluated after the FSM so a done-clear write wins over a same-cycle set.
    if (req) begin
      if (wbs_we_i) begin
        case (off[7:6])
          2'b00: if (ctrl_sel) begin
            irq_en_d = wbs_dat_i[1];
            if (wbs_dat_i[2]) done_d = 1'b0;
            if (wbs_dat_i[0] && !busy) begin
              state_d = S_CLR;
              i_d     = '0;
              j_d     = '0;
              done_d  = 1'b0;
            end
          end
          2'b01: if (e_ok && !busy) a_d[elem] = wbs_dat_i[W-1:0];
          2'b10: if (e_ok && !busy) b_d[elem] = wbs_dat_i[W-1:0];
          default: ;
        endcase
      end else begin
        case (off[7:6])
          2'b00: if (ctrl_sel) dat_d = {29'b0, done_q, irq_en_q, busy};
          2'b01: if (e_ok) dat_d = 32'(a_q[elem]);
          2'b10: if (e_ok) dat_d = 32'(b_q[elem]);
          default: if (e_ok) dat_d = 32'(c_q[elem]);
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      c_q      <= '{default: '0};
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign busy_o    = busy;
  assign irq_o     = done_q & irq_en_q;
  assign mac_clr_o = (state_q == S_CLR);
  assign mac_en_o  = (state_q == S_MAC);
  assign mac_a_o   = mac_en_o ? a_q[a_idx] : '0;
  assign mac_b_o   = mac_en_o ? b_q[b_idx] : '0;

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Self-checking bench for mm_seq_ctrl: behavioural MAC, matrix-product reference
// model, directed cases from the test plan plus randomized matrices.
module tb_mm_seq_ctrl;

  localparam int unsigned N     = 2;
  localparam int unsigned W     = 8;
  localparam int unsigned ACC_W = 2*W + $clog2(N);
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stb = 1'b0, cyc_i = 1'b0, we = 1'b0;
  logic [3:0]       sel = 4'hF;
  logic [31:0]      adr = '0, wdat = '0;
  logic             ack;
  logic [31:0]      rdat;
  logic             mac_clr, mac_en;
  logic [W-1:0]     mac_a, mac_b;
  logic [ACC_W-1:0] acc = '0;
  logic             busy, irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic overlap = 1'b0;
  logic idle_operand = 1'b0;

  int a_m [N*N];
  int b_m [N*N];

  always #5 clk = ~clk;

  mm_seq_ctrl #(.N(N), .W(W), .BASE_ADR(BASE)) dut (
    .wb_clk_i (clk),   .wb_rst_ni(rst_n),
    .wbs_stb_i(stb),   .wbs_cyc_i(cyc_i), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr),   .wbs_dat_i(wdat),  .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .mac_clr_o(mac_clr), .mac_en_o(mac_en), .mac_a_o(mac_a), .mac_b_o(mac_b),
    .mac_acc_i(acc),   .busy_o(busy),     .irq_o(irq)
  );

  // External MAC unit: registered accumulator
  always @(posedge clk) begin
    if (!rst_n)       acc <= '0;
    else if (mac_clr) acc <= '0;
    else if (mac_en)  acc <= acc + mac_a * mac_b;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mac_clr && mac_en) overlap <= 1'b1;
    if (!mac_en && (mac_a != 0 || mac_b != 0)) idle_operand <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] r);
    bit got = 0;
    r = '0;
    @(negedge clk);
    stb = 1'b1; cyc_i = 1'b1; we = w; adr = a; wdat = d;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1;
        r = rdat;
        break;
      end
    end
    stb = 1'b0; cyc_i = 1'b0; we = 1'b0;
    if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] r;
    wb_access(1'b1, BASE + off, d, r);
  endtask

  task automatic wb_read(input logic [31:0] off, output logic [31:0] r);
    wb_access(1'b0, BASE + off, '0, r);
  endtask

  task automatic load_ab();
    for (int e = 0; e < N*N; e++) begin
      wb_write(32'h40 + 4*e, a_m[e]);
      wb_write(32'h80 + 4*e, b_m[e]);
    end
  endtask

  task automatic wait_idle(input int t0, output int n);
    int guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) check_eq("busy_timeout", 32'd1, 32'd0);
    n = cyc - t0;
  endtask

  task automatic check_c(input string tag);
    logic [31:0] r;
    int exp;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp = 0;
        for (int k = 0; k < N; k++) exp += a_m[i*N+k] * b_m[k*N+j];
        wb_read(32'hC0 + 4*(i*N+j), r);
        check_eq(tag, r, exp);
      end
  endtask

  task automatic run(input string tag, input logic ien);
    int t0, n;
    wb_write(32'h00, {30'b0, ien, 1'b1});
    t0 = cyc;
    wait_idle(t0, n);
    check_eq({tag, "_busy_cycles"}, n, N*N*(N+3));
    check_c({tag, "_c"});
  endtask

  initial begin
    logic [31:0] r;
    int t0, n;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outputs", {ack, busy, irq, mac_clr, mac_en}, 0);
    check_eq("rst_operands", {mac_a, mac_b}, 0);
    check_eq("rst_dat", rdat, 0);
    @(negedge clk); rst_n = 1'b1;
    wb_read(32'h00, r); check_eq("rst_ctrl", r, 0);
    @(posedge clk); #1; check_eq("ack_single_pulse", ack, 0);
    wb_read(32'h40, r); check_eq("rst_a0", r, 0);

    // Functional
    a_m = '{1, 2, 3, 4};
    b_m = '{5, 6, 7, 8};
    load_ab();
    run("func", 1'b1);
    wb_read(32'hC0, r); check_eq("func_c00_19", r, 19);
    wb_read(32'hCC, r); check_eq("func_c11_50", r, 50);
    check_eq("func_irq", irq, 1);
    wb_read(32'h00, r); check_eq("func_ctrl", r, 32'h6);

    // Max values
    for (int e = 0; e < N*N; e++) begin a_m[e] = 255; b_m[e] = 255; end
    load_ab();
    run("max", 1'b0);
    wb_read(32'hC4, r); check_eq("max_c01", r, 32'h1FC02);

    // Randomized matrices
    for (int it = 0; it < 6; it++) begin
      for (int e = 0; e < N*N; e++) begin
        a_m[e] = $urandom_range(0, 255);
        b_m[e] = $urandom_range(0, 255);
      end
      load_ab();
      run("rand", 1'($urandom_range(0, 1)));
    end

    // Busy protection
    a_m = '{1, 2, 3, 4};
    b_m = '{5, 6, 7, 8};
    load_ab();
    wb_write(32'h00, 32'h1);
    t0 = cyc;
    wb_write(32'h40, 32'd9);
    wb_write(32'h00, 32'h1);
    check_eq("prot_still_busy", busy, 1);
    wait_idle(t0, n);
    check_eq("prot_busy_cycles", n, 20);
    wb_read(32'h40, r); check_eq("prot_a00", r, 1);
    check_c("prot_c");

    // Interrupt enable and W1C
    check_eq("irq_gated_off", irq, 0);
    wb_write(32'h00, 32'h2);
    check_eq("irq_enabled", irq, 1);
    wb_write(32'h00, 32'h6);
    check_eq("irq_cleared", irq, 0);
    wb_read(32'h00, r); check_eq("w1c_ctrl", r, 32'h2);
    wb_read(32'h10, r); check_eq("unmapped_10", r, 0);
    wb_read(32'h50, r); check_eq("a_e_oob", r, 0);
    wb_write(32'hC0, 32'd77);
    wb_read(32'hC0, r); check_eq("c_ro", r, 19);

    // Address mismatch: no ack
    @(negedge clk);
    stb = 1'b1; cyc_i = 1'b1; we = 1'b0; adr = BASE + 32'h100;
    n = 0;
    repeat (3) begin @(posedge clk); #1; if (ack) n++; end
    stb = 1'b0; cyc_i = 1'b0;
    check_eq("mismatch_no_ack", n, 0);

    // Reset mid-run
    wb_write(32'h00, 32'h3);
    repeat (6) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_outputs", {busy, mac_en, mac_clr, irq}, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int e = 0; e < N*N; e++) begin
      wb_read(32'hC0 + 4*e, r); check_eq("midrst_c_zero", r, 0);
    end
    wb_read(32'h44, r); check_eq("midrst_a_zero", r, 0);
    a_m = '{2, 0, 1, 3};
    b_m = '{4, 5, 6, 7};
    load_ab();
    run("after_rst", 1'b1);
    check_eq("after_rst_irq", irq, 1);

    check_eq("clr_en_exclusive", overlap, 0);
    check_eq("operands_zero_outside_mac", idle_operand, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
